// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 control unit: opcodes, ALU modes,
// sequencer states and the control word driven towards the datapath.
package mu0_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    localparam logic [1:0] ALU_Y   = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_INC = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10
    } state_t;

    typedef struct packed {
        logic       x_sel;
        logic       y_sel;
        logic       addr_sel;
        logic       pc_en;
        logic       ir_en;
        logic       acc_en;
        logic [1:0] m;
        logic       rd;
        logic       wr;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mu0_decode.sv
// Combinational EXEC-cycle decode of opcode and flags into a control word.
// Memory-ready gating is left to the sequencer.
module mu0_decode
    import mu0_pkg::*;
(
    input  logic [3:0] f,
    input  logic       n,
    input  logic       z,
    output ctrl_t      ctrl,
    output logic       is_mem,
    output logic       is_stp
);

    // Opcode table; conditional jumps resolve against the live flags.
    always_comb begin
        ctrl   = '0;
        is_mem = 1'b0;
        is_stp = 1'b0;
        case (f)
            OP_LDA: begin
                ctrl.addr_sel = 1'b1;
                ctrl.rd       = 1'b1;
                ctrl.m        = ALU_Y;
                ctrl.acc_en   = 1'b1;
                is_mem        = 1'b1;
            end
            OP_STA: begin
                ctrl.addr_sel = 1'b1;
                ctrl.wr       = 1'b1;
                is_mem        = 1'b1;
            end
            OP_ADD: begin
                ctrl.addr_sel = 1'b1;
                ctrl.rd       = 1'b1;
                ctrl.m        = ALU_ADD;
                ctrl.acc_en   = 1'b1;
                is_mem        = 1'b1;
            end
            OP_SUB: begin
                ctrl.addr_sel = 1'b1;
                ctrl.rd       = 1'b1;
                ctrl.m        = ALU_SUB;
                ctrl.acc_en   = 1'b1;
                is_mem        = 1'b1;
            end
            OP_JMP: begin
                ctrl.y_sel = 1'b1;
                ctrl.m     = ALU_Y;
                ctrl.pc_en = 1'b1;
            end
            OP_JGE: begin
                if (!n) begin
                    ctrl.y_sel = 1'b1;
                    ctrl.m     = ALU_Y;
                    ctrl.pc_en = 1'b1;
                end
            end
            OP_JNE: begin
                if (!z) begin
                    ctrl.y_sel = 1'b1;
                    ctrl.m     = ALU_Y;
                    ctrl.pc_en = 1'b1;
                end
            end
            OP_STP: begin
                is_stp = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit: FETCH/EXEC/HALT sequencer with memory-ready stalls,
// combinational control outputs and a retired-instruction counter.
module mu0_control
    import mu0_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [3:0]       F,
    input  logic             N,
    input  logic             Z,
    input  logic             Mem_Rdy,
    output logic             X_sel,
    output logic             Y_sel,
    output logic             Addr_sel,
    output logic             PC_En,
    output logic             IR_En,
    output logic             Acc_En,
    output logic [1:0]       M,
    output logic             Rd,
    output logic             Wr,
    output logic             Halted,
    output logic             Illegal,
    output logic [CNT_W-1:0] Instr_Count
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    ctrl_t            dec;
    ctrl_t            ctrl;
    logic             is_mem;
    logic             is_stp;
    logic             exec_done;
    logic             halted;

    mu0_decode u_decode (
        .f      (F),
        .n      (N),
        .z      (Z),
        .ctrl   (dec),
        .is_mem (is_mem),
        .is_stp (is_stp)
    );

    // Memory instructions retire only once the access is acknowledged.
    assign exec_done = (state == EXEC) && (!is_mem || Mem_Rdy);

    // Next-state selection, including wait-state holds.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   state_nxt = Mem_Rdy ? EXEC : FETCH;
            EXEC:    if (exec_done) state_nxt = is_stp ? HALT : FETCH;
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    // State register and retired-instruction counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= FETCH;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (exec_done) count <= count + 1'b1;
        end
    end

    // Control outputs; reset overrides combinationally so an aborted
    // instruction never leaks an enable during the reset cycle.
    always_comb begin
        ctrl   = '0;
        halted = 1'b0;
        if (Reset) begin
            ctrl.x_sel = 1'b1;
            ctrl.m     = ALU_INC;
        end else begin
            case (state)
                FETCH: begin
                    ctrl.x_sel = 1'b1;
                    ctrl.rd    = 1'b1;
                    ctrl.m     = ALU_INC;
                    ctrl.ir_en = Mem_Rdy;
                    ctrl.pc_en = Mem_Rdy;
                end
                EXEC: begin
                    ctrl        = dec;
                    ctrl.acc_en = dec.acc_en & Mem_Rdy;
                end
                HALT:    halted = 1'b1;
                default: ctrl = '0;
            endcase
        end
    end

    assign X_sel       = ctrl.x_sel;
    assign Y_sel       = ctrl.y_sel;
    assign Addr_sel    = ctrl.addr_sel;
    assign PC_En       = ctrl.pc_en;
    assign IR_En       = ctrl.ir_en;
    assign Acc_En      = ctrl.acc_en;
    assign M           = ctrl.m;
    assign Rd          = ctrl.rd;
    assign Wr          = ctrl.wr;
    assign Illegal     = ctrl.illegal;
    assign Halted      = halted;
    assign Instr_Count = count;

endmodule

// File: tb/tb_mu0_control.sv
// Self-checking bench for mu0_control: directed instruction sequences plus
// randomized programs with random wait states, checked cycle by cycle
// against an instruction-level expectation table.
module tb_mu0_control;
    import mu0_pkg::*;

    localparam int PH_RESET = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_EXEC  = 2;
    localparam int PH_HALT  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  f;
    logic        n;
    logic        z;
    logic        mem_rdy;

    logic        x_sel, y_sel, addr_sel, pc_en, ir_en, acc_en, rd, wr, halted, illegal;
    logic [1:0]  m;
    logic [15:0] instr_count;

    logic        x_sel4, y_sel4, addr_sel4, pc_en4, ir_en4, acc_en4, rd4, wr4, halted4, illegal4;
    logic [1:0]  m4;
    logic [3:0]  instr_count4;

    logic [11:0] dut_word;
    logic [11:0] dut_word4;
    logic [15:0] exp_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mu0_control #(.CNT_W(16)) u_dut (
        .Clk(clk), .Reset(rst), .F(f), .N(n), .Z(z), .Mem_Rdy(mem_rdy),
        .X_sel(x_sel), .Y_sel(y_sel), .Addr_sel(addr_sel), .PC_En(pc_en),
        .IR_En(ir_en), .Acc_En(acc_en), .M(m), .Rd(rd), .Wr(wr),
        .Halted(halted), .Illegal(illegal), .Instr_Count(instr_count)
    );

    // Narrow counter instance: exposes counter wrap within a short run.
    mu0_control #(.CNT_W(4)) u_dut4 (
        .Clk(clk), .Reset(rst), .F(f), .N(n), .Z(z), .Mem_Rdy(mem_rdy),
        .X_sel(x_sel4), .Y_sel(y_sel4), .Addr_sel(addr_sel4), .PC_En(pc_en4),
        .IR_En(ir_en4), .Acc_En(acc_en4), .M(m4), .Rd(rd4), .Wr(wr4),
        .Halted(halted4), .Illegal(illegal4), .Instr_Count(instr_count4)
    );

    assign dut_word  = {x_sel, y_sel, addr_sel, pc_en, ir_en, acc_en, m, rd, wr, halted, illegal};
    assign dut_word4 = {x_sel4, y_sel4, addr_sel4, pc_en4, ir_en4, acc_en4, m4, rd4, wr4, halted4, illegal4};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Expected outputs for one cycle, straight from the instruction table.
    function automatic logic [11:0] exp_word(input int ph, input logic [3:0] op,
                                             input logic fn, input logic fz, input logic rdy);
        logic xs, ys, as, pe, ie, ae, r, w, h, il;
        logic [1:0] mm;
        {xs, ys, as, pe, ie, ae, r, w, h, il} = '0;
        mm = 2'b00;
        case (ph)
            PH_RESET: begin xs = 1'b1; mm = 2'b10; end
            PH_FETCH: begin xs = 1'b1; r = 1'b1; mm = 2'b10; ie = rdy; pe = rdy; end
            PH_HALT:  h = 1'b1;
            default: begin
                if (op == 4'd0) begin as = 1'b1; r = 1'b1; ae = rdy; end
                else if (op == 4'd1) begin as = 1'b1; w = 1'b1; end
                else if (op == 4'd2) begin as = 1'b1; r = 1'b1; ae = rdy; mm = 2'b01; end
                else if (op == 4'd3) begin as = 1'b1; r = 1'b1; ae = rdy; mm = 2'b11; end
                else if ((op == 4'd4) || (op == 4'd5 && !fn) || (op == 4'd6 && !fz)) begin
                    ys = 1'b1; pe = 1'b1;
                end
                else if (op >= 4'd8) il = 1'b1;
            end
        endcase
        return {xs, ys, as, pe, ie, ae, mm, r, w, h, il};
    endfunction

    // One clock cycle: apply inputs at the falling edge, check, move on.
    task automatic cyc(input int ph, input logic [3:0] op, input logic fn, input logic fz,
                       input logic rdy, input string tag);
        logic [11:0] e;
        f = op; n = fn; z = fz; mem_rdy = rdy;
        #1;
        e = exp_word(ph, op, fn, fz, rdy);
        check({tag, " ctrl"}, 32'(dut_word), 32'(e));
        check({tag, " ctrl4"}, 32'(dut_word4), 32'(e));
        check({tag, " count"}, 32'(instr_count), 32'(exp_count));
        check({tag, " count4"}, 32'(instr_count4), 32'(exp_count[3:0]));
        @(negedge clk);
    endtask

    task automatic fetch_phase(input int waits);
        for (int i = 0; i < waits; i++)
            cyc(PH_FETCH, 4'($urandom), 1'($urandom), 1'($urandom), 1'b0, "fetch_wait");
        cyc(PH_FETCH, 4'($urandom), 1'($urandom), 1'($urandom), 1'b1, "fetch");
    endtask

    task automatic exec_phase(input logic [3:0] op, input logic fn, input logic fz, input int waits);
        if (op <= 4'd3) begin
            for (int i = 0; i < waits; i++) cyc(PH_EXEC, op, fn, fz, 1'b0, "exec_wait");
            cyc(PH_EXEC, op, fn, fz, 1'b1, "exec");
        end else begin
            cyc(PH_EXEC, op, fn, fz, 1'($urandom), "exec");
        end
        exp_count = exp_count + 16'd1;
    endtask

    task automatic do_instr(input logic [3:0] op, input logic fn, input logic fz,
                            input int fw, input int ew);
        fetch_phase(fw);
        exec_phase(op, fn, fz, ew);
    endtask

    task automatic halt_phase(input int cycles);
        for (int i = 0; i < cycles; i++)
            cyc(PH_HALT, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "halt");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_count = '0;
        cyc(PH_RESET, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "reset");
        cyc(PH_RESET, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "reset");
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        rst = 1'b1; f = '0; n = 1'b0; z = 1'b0; mem_rdy = 1'b1;
        exp_count = '0;
        @(negedge clk);
        do_reset();

        // Basic instruction set, zero-wait memory.
        do_instr(OP_LDA, 1'b0, 1'b0, 0, 0);
        do_instr(OP_ADD, 1'b0, 1'b0, 0, 0);
        do_instr(OP_SUB, 1'b1, 1'b0, 0, 0);
        do_instr(OP_STA, 1'b0, 1'b1, 0, 0);
        do_instr(OP_JGE, 1'b1, 1'b0, 0, 0);
        do_instr(OP_JGE, 1'b0, 1'b0, 0, 0);
        do_instr(OP_JNE, 1'b0, 1'b1, 0, 0);
        do_instr(OP_JNE, 1'b0, 1'b0, 0, 0);
        do_instr(OP_JMP, 1'b1, 1'b1, 0, 0);

        // Wait states during fetch and during a load.
        do_instr(OP_LDA, 1'b0, 1'b0, 3, 3);
        do_instr(OP_STA, 1'b0, 1'b0, 1, 2);

        // Illegal opcode followed by a normal fetch.
        do_instr(4'h9, 1'b0, 1'b0, 0, 0);
        do_instr(OP_JMP, 1'b0, 1'b0, 0, 0);

        // Stop: halt persists regardless of inputs until reset.
        do_instr(OP_STP, 1'b0, 1'b0, 0, 0);
        halt_phase(12);
        do_reset();

        // Reset asserted in the middle of a fetch wait.
        cyc(PH_FETCH, 4'h0, 1'b0, 1'b0, 1'b0, "fetch_wait");
        #2 rst = 1'b1; exp_count = '0;
        #1;
        check("abort_fetch ctrl", 32'(dut_word), 32'(exp_word(PH_RESET, 4'h0, 1'b0, 1'b0, 1'b0)));
        @(negedge clk);
        do_reset();

        // Reset asserted in the middle of a load wait.
        do_instr(OP_ADD, 1'b0, 1'b0, 0, 0);
        fetch_phase(0);
        cyc(PH_EXEC, OP_LDA, 1'b0, 1'b0, 1'b0, "exec_wait");
        cyc(PH_EXEC, OP_LDA, 1'b0, 1'b0, 1'b0, "exec_wait");
        #2 rst = 1'b1; exp_count = '0;
        #1;
        check("abort_exec ctrl", 32'(dut_word), 32'(exp_word(PH_RESET, OP_LDA, 1'b0, 1'b0, 1'b0)));
        check("abort_exec count", 32'(instr_count), 32'(exp_count));
        @(negedge clk);
        do_reset();
        do_instr(OP_LDA, 1'b0, 1'b0, 0, 0);

        // Eighteen non-stop instructions: narrow counter wraps past 15.
        for (int i = 0; i < 18; i++) begin
            op = 4'($urandom_range(0, 6));
            do_instr(op, 1'($urandom), 1'($urandom), 0, 0);
        end

        // Randomized programs with random waits.
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            do_instr(op, 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
            if (op == OP_STP) begin
                halt_phase(3);
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
